// File: rtl/id_stage_pipe.sv
// Registered MIPS instruction-decode stage with register file, branch resolution and load-use stall.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data into operand reads.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_next_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_ctrl,
  output logic            alu_b_sel,
  output logic [4:0]      dst_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            wb_data_sel,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_LW   = 6'd4;
  localparam logic [5:0] OP_SW   = 6'd5;
  localparam logic [5:0] OP_AND  = 6'd6;
  localparam logic [5:0] OP_OR   = 6'd7;
  localparam logic [5:0] OP_NOR  = 6'd8;
  localparam logic [5:0] OP_BEQ  = 6'd9;
  localparam logic [5:0] OP_BNE  = 6'd10;
  localparam logic [5:0] OP_SLT  = 6'd11;
  localparam logic [5:0] OP_EOF  = 6'd12;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [5:0] NUM_REGS6 = 6'(NUM_REGS);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic            squash;
  logic [XLEN-1:0] rf [32];

  logic [5:0]      op;
  logic [4:0]      rs_a, rt_a, rd_a;
  logic [3:0]      dec_alu;
  logic            dec_b_sel, dec_rw, dec_mr, dec_mw, dec_wbs;
  logic [4:0]      dec_dst;
  logic            uses_rt, is_beq, is_bne, is_eof;
  logic [XLEN-1:0] rs_val, rt_val, imm_sext;
  logic [PC_W-1:0] br_target;
  logic            br_taken, hazard, accept;

  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NUM_REGS6);
  endfunction

  assign op       = instr[31:26];
  assign rs_a     = instr[25:21];
  assign rt_a     = instr[20:16];
  assign rd_a     = instr[15:11];
  assign imm_sext = XLEN'($signed(instr[15:0]));

  always_comb begin
    dec_alu   = ALU_ADD;
    dec_b_sel = 1'b0;
    dec_dst   = 5'd0;
    dec_rw    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_wbs   = 1'b0;
    uses_rt   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_eof    = 1'b0;
    case (op)
      OP_ADD: begin dec_alu = ALU_ADD; dec_dst = rd_a; dec_rw = 1'b1; uses_rt = 1'b1; end
      OP_SUB: begin dec_alu = ALU_SUB; dec_dst = rd_a; dec_rw = 1'b1; uses_rt = 1'b1; end
      OP_AND: begin dec_alu = ALU_AND; dec_dst = rd_a; dec_rw = 1'b1; uses_rt = 1'b1; end
      OP_OR:  begin dec_alu = ALU_OR;  dec_dst = rd_a; dec_rw = 1'b1; uses_rt = 1'b1; end
      OP_NOR: begin dec_alu = ALU_NOR; dec_dst = rd_a; dec_rw = 1'b1; uses_rt = 1'b1; end
      OP_SLT: begin dec_alu = ALU_SLT; dec_dst = rd_a; dec_rw = 1'b1; uses_rt = 1'b1; end
      OP_ADDI: begin
        dec_b_sel = 1'b1;
        dec_dst   = rt_a;
        dec_rw    = 1'b1;
      end
      OP_LW: begin
        dec_b_sel = 1'b1;
        dec_dst   = rt_a;
        dec_rw    = 1'b1;
        dec_mr    = 1'b1;
        dec_wbs   = 1'b1;
      end
      OP_SW: begin
        dec_b_sel = 1'b1;
        dec_mw    = 1'b1;
        uses_rt   = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; uses_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; uses_rt = 1'b1; end
      OP_EOF: is_eof = 1'b1;
      default: ;
    endcase
  end

  // Without the bypass a same-cycle write is invisible until the next cycle.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (addr_ok(rs_a)) rs_val = rf[rs_a];
    if (addr_ok(rt_a)) rt_val = rf[rt_a];
`ifdef WB_BYPASS_EN
    if (wb_en && addr_ok(wb_addr) && wb_addr == rs_a) rs_val = wb_data;
    if (wb_en && addr_ok(wb_addr) && wb_addr == rt_a) rt_val = wb_data;
`endif
  end

  assign br_taken  = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
  assign br_target = pc_next_in + PC_W'($signed({instr[15:0], 2'b00}));

  assign hazard = out_valid && mem_read && (dst_addr != 5'd0) &&
                  ((dst_addr == rs_a) || (uses_rt && (dst_addr == rt_a)));

  assign in_ready = reset && (!out_valid || out_ready) && !hazard && (state == RUN);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && addr_ok(wb_addr)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // A squashed instruction is consumed from fetch but leaves no trace downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      squash         <= 1'b0;
      out_valid      <= 1'b0;
      rs_data        <= '0;
      rt_data        <= '0;
      imm            <= '0;
      alu_ctrl       <= 4'd0;
      alu_b_sel      <= 1'b0;
      dst_addr       <= 5'd0;
      reg_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      wb_data_sel    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (accept) begin
        if (squash) begin
          squash    <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          out_valid   <= 1'b1;
          rs_data     <= rs_val;
          rt_data     <= rt_val;
          imm         <= imm_sext;
          alu_ctrl    <= dec_alu;
          alu_b_sel   <= dec_b_sel;
          dst_addr    <= dec_dst;
          reg_write   <= dec_rw;
          mem_read    <= dec_mr;
          mem_write   <= dec_mw;
          wb_data_sel <= dec_wbs;
          if (br_taken) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= br_target;
            squash         <= 1'b1;
          end
          if (is_eof) state <= HALT;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomised bench for id_stage_pipe against a cycle-level behavioural model of the decode stage.
module tb_id_stage_pipe;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc_next_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] rs_data, rt_data, imm;
  logic [3:0]  alu_ctrl;
  logic        alu_b_sel;
  logic [4:0]  dst_addr;
  logic        reg_write, mem_read, mem_write, wb_data_sel;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic last_in_ready;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_next_in(pc_next_in), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_ctrl(alu_ctrl),
    .alu_b_sel(alu_b_sel), .dst_addr(dst_addr), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .wb_data_sel(wb_data_sel),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural registers plus what EX should currently see.
  logic [31:0] m_regs [32];
  logic        m_ov, m_rv, m_squash, m_halt;
  logic [31:0] m_rs, m_rt, m_imm, m_rpc;
  logic [3:0]  m_alu;
  logic        m_bsel, m_rw, m_mr, m_mw, m_wbs;
  logic [4:0]  m_dst;

  typedef enum int {K_PLAIN, K_BEQ, K_BNE, K_EOF} kind_t;
  typedef struct {
    int    alu;
    bit    bsel, rw, mr, mw, wbs, rt_used;
    int    dst;
    kind_t kind;
  } ref_dec_t;

  function automatic ref_dec_t ref_decode(input logic [31:0] ins);
    ref_dec_t d;
    int op = int'(ins[31:26]);
    d = '{alu: 0, bsel: 0, rw: 0, mr: 0, mw: 0, wbs: 0, rt_used: 0, dst: 0, kind: K_PLAIN};
    case (op)
      1, 2, 6, 7, 8, 11: begin
        case (op)
          1: d.alu = 0;  2: d.alu = 1;  6: d.alu = 2;
          7: d.alu = 3;  8: d.alu = 4;  default: d.alu = 5;
        endcase
        d.dst = int'(ins[15:11]); d.rw = 1; d.rt_used = 1;
      end
      3: begin d.bsel = 1; d.dst = int'(ins[20:16]); d.rw = 1; end
      4: begin d.bsel = 1; d.dst = int'(ins[20:16]); d.rw = 1; d.mr = 1; d.wbs = 1; end
      5: begin d.bsel = 1; d.mw = 1; d.rt_used = 1; end
      9:  begin d.kind = K_BEQ; d.rt_used = 1; end
      10: begin d.kind = K_BNE; d.rt_used = 1; end
      12: d.kind = K_EOF;
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_ov = 0; m_rv = 0; m_squash = 0; m_halt = 0;
    m_rs = 0; m_rt = 0; m_imm = 0; m_rpc = 0; m_alu = 0;
    m_bsel = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_wbs = 0; m_dst = 0;
  endtask

  task automatic check_output(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic compare_bundle();
    check_output("out_valid", 64'(out_valid), 64'(m_ov));
    check_output("rs_data", 64'(rs_data), 64'(m_rs));
    check_output("rt_data", 64'(rt_data), 64'(m_rt));
    check_output("imm", 64'(imm), 64'(m_imm));
    check_output("alu_ctrl", 64'(alu_ctrl), 64'(m_alu));
    check_output("alu_b_sel", 64'(alu_b_sel), 64'(m_bsel));
    check_output("dst_addr", 64'(dst_addr), 64'(m_dst));
    check_output("reg_write", 64'(reg_write), 64'(m_rw));
    check_output("mem_read", 64'(mem_read), 64'(m_mr));
    check_output("mem_write", 64'(mem_write), 64'(m_mw));
    check_output("wb_data_sel", 64'(wb_data_sel), 64'(m_wbs));
    check_output("redirect_valid", 64'(redirect_valid), 64'(m_rv));
    check_output("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    check_output("halted", 64'(halted), 64'(m_halt));
  endtask

  // One clock cycle: drive, check the combinational ready, advance the model, check the bundle.
  task automatic apply_stimulus(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                                input bit we, input logic [4:0] wa, input logic [31:0] wd,
                                input bit ordy);
    ref_dec_t    d;
    logic [4:0]  rs_a, rt_a;
    logic [31:0] rsv, rtv;
    bit          hz, rdy, taken;
    @(negedge clk);
    in_valid = v; instr = ins; pc_next_in = pc;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    rs_a = ins[25:21];
    rt_a = ins[20:16];
    d    = ref_decode(ins);
    hz   = m_ov && m_mr && (m_dst != 0) && ((m_dst == rs_a) || (d.rt_used && m_dst == rt_a));
    rdy  = (!m_ov || ordy) && !hz && !m_halt;
    check_output("in_ready", 64'(in_ready), 64'(rdy));
    last_in_ready = in_ready;
    rsv = ref_read(rs_a, we, wa, wd);
    rtv = ref_read(rt_a, we, wa, wd);
    m_rv = 0;
    if (v && rdy) begin
      if (m_squash) begin
        m_squash = 0;
        m_ov = 0;
      end else begin
        m_ov = 1; m_rs = rsv; m_rt = rtv;
        m_imm  = 32'($signed(ins[15:0]));
        m_alu  = 4'(d.alu); m_bsel = d.bsel; m_dst = 5'(d.dst);
        m_rw = d.rw; m_mr = d.mr; m_mw = d.mw; m_wbs = d.wbs;
        taken = (d.kind == K_BEQ && rsv == rtv) || (d.kind == K_BNE && rsv != rtv);
        if (taken) begin
          m_rv = 1;
          m_rpc = pc + 32'($signed(ins[15:0])) * 32'd4;
          m_squash = 1;
        end
        if (d.kind == K_EOF) m_halt = 1;
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    if (we && wa != 0) m_regs[wa] = wd;
    @(posedge clk);
    #1;
    compare_bundle();
  endtask

  task automatic check_reset_state();
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_halted", 64'(halted), 64'd0);
    check_output("rst_redirect", 64'(redirect_valid), 64'd0);
    check_output("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check_output("rst_rs_data", 64'(rs_data), 64'd0);
    check_output("rst_dst_addr", 64'(dst_addr), 64'd0);
    check_output("rst_ctrl", 64'({alu_ctrl, alu_b_sel, reg_write, mem_read, mem_write, wb_data_sel}), 64'd0);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; wb_en = 0; out_ready = 0;
    #2 reset = 1'b0;
    #1 check_reset_state();
    model_reset();
    #1 reset = 1'b1;
  endtask

  task automatic idle_wb(input logic [4:0] wa, input logic [31:0] wd);
    apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1, wa, wd, 1'b1);
  endtask

  int ops [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 20, 63};

  initial begin
    in_valid = 0; instr = 0; pc_next_in = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    out_ready = 0;
    reset = 1'b0;
    model_reset();
    #2 check_reset_state();
    #2 reset = 1'b1;

    idle_wb(5'd1, 32'd5);
    idle_wb(5'd2, 32'd5);
    apply_stimulus(1'b1, 32'h04221800, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_add_valid", 64'(out_valid), 64'd1);
    check_output("tp_add_rs", 64'(rs_data), 64'd5);
    check_output("tp_add_rt", 64'(rt_data), 64'd5);
    check_output("tp_add_dst", 64'(dst_addr), 64'd3);

    apply_stimulus(1'b1, 32'h0C04FFFF, 32'h8, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_addi_imm", 64'(imm), 64'hFFFFFFFF);
    check_output("tp_addi_bsel", 64'(alu_b_sel), 64'd1);

    apply_stimulus(1'b1, 32'h10050000, 32'hC, 1'b0, 5'd0, 32'd0, 1'b1);
    apply_stimulus(1'b1, 32'h04A03000, 32'h10, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_hz_stall", 64'(last_in_ready), 64'd0);
    check_output("tp_hz_bubble", 64'(out_valid), 64'd0);
    apply_stimulus(1'b1, 32'h04A03000, 32'h10, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_hz_accept", 64'(last_in_ready), 64'd1);
    check_output("tp_hz_dst", 64'(dst_addr), 64'd6);

    apply_stimulus(1'b1, 32'h24220003, 32'h10, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_br_pulse", 64'(redirect_valid), 64'd1);
    check_output("tp_br_pc", 64'(redirect_pc), 64'h1C);
    apply_stimulus(1'b1, 32'h0C070001, 32'h14, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_br_squash", 64'(out_valid), 64'd0);
    check_output("tp_br_pulse_end", 64'(redirect_valid), 64'd0);

    apply_stimulus(1'b1, 32'h04221800, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h0C080002, 32'h24, 1'b0, 5'd0, 32'd0, 1'b0);
      check_output("tp_hold_ready", 64'(last_in_ready), 64'd0);
      check_output("tp_hold_dst", 64'(dst_addr), 64'd3);
    end
    apply_stimulus(1'b1, 32'h0C080002, 32'h24, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_release_dst", 64'(dst_addr), 64'd8);

    apply_stimulus(1'b1, 32'h00C00000, 32'h28, 1'b1, 5'd6, 32'd9, 1'b1);
`ifdef WB_BYPASS_EN
    check_output("tp_bypass", 64'(rs_data), 64'd9);
`else
    check_output("tp_no_bypass", 64'(rs_data), 64'd0);
`endif

    apply_stimulus(1'b1, 32'h30000000, 32'h2C, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_eof_halted", 64'(halted), 64'd1);
    apply_stimulus(1'b1, 32'h04221800, 32'h30, 1'b0, 5'd0, 32'd0, 1'b1);
    check_output("tp_eof_ready", 64'(last_in_ready), 64'd0);
    do_reset();

    for (int n = 0; n < 800; n++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic [5:0]  op;
        logic [31:0] ins;
        op = ($urandom_range(0, 59) == 0) ? 6'd12 : 6'(ops[$urandom_range(0, 14)]);
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)};
        apply_stimulus($urandom_range(0, 3) != 0, ins, $urandom,
                       $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)),
                       $urandom_range(0, 3) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered instruction-decode stage for the single-cycle MIPS core's move to a pipelined datapath.
- Decodes the team's 6-bit opcode set, reads an internal parametrised register file, resolves beq/bne in decode, and detects load-use hazards.
- Drives a registered ID/EX output bundle under a valid/ready handshake.
- Adds halt on eof and a one-cycle squash of the instruction after a taken branch.

Parameters:
XLEN, 32, datapath and register width in bits (>= 16)
NUM_REGS, 32, register file entries (2..32); addresses >= NUM_REGS read 0 and ignore writes
PC_W, 32, program counter width in bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instr/pc_next_in
in_ready  out  1  stage accepts instruction this cycle
instr  in  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
pc_next_in  in  PC_W  PC+4 of instr
wb_en  in  1  write-back write enable
wb_addr  in  5  write-back register
wb_data  in  XLEN  write-back data
out_valid  out  1  ID/EX bundle valid
out_ready  in  1  EX accepts bundle
rs_data, rt_data  out  XLEN  operand reads
imm  out  XLEN  sign-extended instr[15:0]
alu_ctrl  out  4  0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt
alu_b_sel  out  1  1 = imm, 0 = rt_data
dst_addr  out  5  rd (R-type) or rt (addi/lw)
reg_write, mem_read, mem_write, wb_data_sel  out  1 each  control bits
redirect_valid  out  1  one-cycle pulse: taken branch
redirect_pc  out  PC_W  branch target
halted  out  1  eof decoded

Behaviour:
- Reset (async, reset=0): all outputs 0, all registers cleared, state RUN, squash flag 0.
- Opcodes: 1 add, 2 sub, 6 and, 7 or, 8 nor, 11 slt (R-type: alu_b_sel 0, dst rd, reg_write 1); 3 addi (alu 0, alu_b_sel 1, dst rt, reg_write 1); 4 lw (addi plus mem_read 1, wb_data_sel 1); 5 sw (alu 0, alu_b_sel 1, mem_write 1, reg_write 0); 9 beq; 10 bne; 12 eof.
- Opcode 0 and any undefined opcode decode as a NOP bundle: all control bits 0, out_valid 1.
- Register file: reads combinational; write on clk edge when wb_en=1; register 0 is read-only zero.
- Handshake: the bundle register loads when in_valid && in_ready, giving 1-cycle latency. in_ready = (!out_valid || out_ready) && !hazard && state==RUN. The bundle holds stable while out_valid && !out_ready. out_valid clears when the bundle is consumed and nothing is loaded.
- Load-use hazard:
  - Condition: out_valid && mem_read && dst_addr!=0 && dst_addr matches instr rs, or matches instr rt when instr is R-type, sw, beq, or bne.
  - Response: in_ready=0; once the lw is consumed, a bubble is inserted (out_valid 0 for one cycle).
- Branch: on accepting beq/bne, compare rs/rt. If taken, redirect_valid pulses for 1 cycle, registered, with redirect_pc = pc_next_in + (sext(imm) << 2), truncated to PC_W. The next accepted instruction is squashed: in_ready 1, bundle not loaded, squash flag cleared. Branches emit a NOP bundle to EX.
- eof: on acceptance, move to state HALT. halted=1, in_ready=0, no further bundles. Only reset leaves HALT.
- wb write and read of the same register in the same cycle: old value is read (see optional feature).
- Reset mid-operation: bundle, pending squash, and HALT are all discarded immediately.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when wb_en && wb_addr==rs (or rt) && wb_addr!=0, the operand read and the branch comparison return wb_data in the same cycle.
- Undefined: the register file value from before the write is returned.

Test Plan:
- Reset, then write r1=5, r2=5 via wb; present add rd=3 rs=1 rt=2 (0x04221800) -> next cycle out_valid=1, alu_ctrl=0, dst_addr=3, reg_write=1, rs_data=5, rt_data=5.
- addi r4,r0,-1 (0x0C04FFFF) -> imm=0xFFFFFFFF, alu_b_sel=1, dst_addr=4.
- lw r5 accepted, then add using rs=5 with out_ready=1 -> in_ready=0 for 1 cycle, one bubble cycle, then add accepted.
- beq r1,r2,+3 at pc_next_in=0x10 with r1=r2 -> redirect_valid=1 for 1 cycle, redirect_pc=0x1C; next presented instruction dropped, out_valid stays 0.
- out_ready=0 for 3 cycles with bundle held -> in_ready=0, bundle fields unchanged; release -> next instruction loads.
- eof (0x30000000) -> halted=1, in_ready=0; assert reset mid-halt -> halted=0, out_valid=0; with WB_BYPASS_EN, wb r6=9 while reading r6 -> rs_data=9.
